des_key_sched_ctrl: RTL and testbench

- Sequences the DES key schedule for the round datapath.
- Loads a 64-bit key, applies PC-1 and splits it into 28-bit C/D halves.
- Steps C/D once per round using the per-round rotate amount (1 or 2), applies PC-2, and hands each 48-bit subkey to the round engine over a valid/ready handshake.
- Sits between the key input register and the Feistel round unit.

---
 rtl/des_key_pkg.sv | 52 +++++
 rtl/des_key_rot.sv | 23 ++
 rtl/des_key_sched_ctrl.sv | 147 ++++++++++++++
 tb/tb_des_key_sched_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_key_pkg.sv
// Shared constants, permutation tables and helpers for the DES key scheduler.
// Used by des_key_sched_ctrl and des_key_rot.
package des_key_pkg;

    localparam int KEY_W    = 64;
    localparam int HALF_W   = 28;
    localparam int CD_W     = 56;
    localparam int SUBKEY_W = 48;

    // Bit r-1 set means round r rotates by one position, otherwise by two.
    localparam logic [15:0] SHIFT_ONE_MASK = 16'b1000_0001_0000_0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Tables use DES numbering: entry 1 selects the most significant bit.
    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
        logic [CD_W-1:0] cd;
        cd = '0;
        for (int i = 0; i < CD_W; i++) begin
            cd[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
        end
        return cd;
    endfunction

    function automatic logic [SUBKEY_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SUBKEY_W-1:0] sk;
        sk = '0;
        for (int i = 0; i < SUBKEY_W; i++) begin
            sk[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        end
        return sk;
    endfunction

endpackage

// File: rtl/des_key_rot.sv
// Combinational 28-bit circular rotator for one key half (by 1 or 2, left or right).
module des_key_rot
    import des_key_pkg::*;
(
    input  logic [HALF_W-1:0] in_half,
    input  logic [1:0]        amt,
    input  logic              dir_right,
    output logic [HALF_W-1:0] out_half
);

    // Select rotation by direction and amount; unused amounts pass through.
    always_comb begin
        out_half = in_half;
        case ({dir_right, amt})
            3'b001:  out_half = {in_half[HALF_W-2:0], in_half[HALF_W-1]};
            3'b010:  out_half = {in_half[HALF_W-3:0], in_half[HALF_W-1:HALF_W-2]};
            3'b101:  out_half = {in_half[0], in_half[HALF_W-1:1]};
            3'b110:  out_half = {in_half[1:0], in_half[HALF_W-1:2]};
            default: out_half = in_half;
        endcase
    end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// DES key schedule sequencer: PC-1 load, per-round C/D rotation, PC-2 subkeys over valid/ready.
// Reverse-order (decrypt) generation is built only when DES_KEY_DECRYPT_EN is defined.
module des_key_sched_ctrl
    import des_key_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                decrypt,
    input  logic [KEY_W-1:0]    key_in,
    output logic                busy,
    output logic [SUBKEY_W-1:0] subkey,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic [3:0]          round_idx,
    output logic                done
);

    state_e              state_q, state_d;
    logic [HALF_W-1:0]   c_q, c_d, d_q, d_d;
    logic [3:0]          round_q, round_d;
    logic                dec_q, dec_d;

    logic [CD_W-1:0]     pc1_s;
    logic [HALF_W-1:0]   src_c_s, src_d_s, rot_c_s, rot_d_s;
    logic [3:0]          shift_idx_s;
    logic [1:0]          amt_s;
    logic                dir_right_s;
    logic                final_s;
    logic                dec_req_s;

`ifdef DES_KEY_DECRYPT_EN
    assign dec_req_s = decrypt;
`else
    logic unused_decrypt_s;
    assign unused_decrypt_s = decrypt;
    assign dec_req_s        = 1'b0;
`endif

    assign pc1_s = pc1(key_in);

    // Rotator feed: the load path rotates PC-1 by shift(1); RUN steps to the next round.
    always_comb begin
        if (state_q == ST_RUN) begin
            src_c_s     = c_q;
            src_d_s     = d_q;
            dir_right_s = dec_q;
            shift_idx_s = dec_q ? round_q : round_q + 4'd1;
        end else begin
            src_c_s     = pc1_s[CD_W-1:HALF_W];
            src_d_s     = pc1_s[HALF_W-1:0];
            dir_right_s = 1'b0;
            shift_idx_s = 4'd0;
        end
        amt_s = SHIFT_ONE_MASK[shift_idx_s] ? 2'd1 : 2'd2;
    end

    des_key_rot u_rot_c (
        .in_half   (src_c_s),
        .amt       (amt_s),
        .dir_right (dir_right_s),
        .out_half  (rot_c_s)
    );

    des_key_rot u_rot_d (
        .in_half   (src_d_s),
        .amt       (amt_s),
        .dir_right (dir_right_s),
        .out_half  (rot_d_s)
    );

    assign final_s = dec_q ? (round_q == 4'd0) : (round_q == 4'(ROUNDS - 1));

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        dec_d   = dec_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dec_d   = dec_req_s;
                    state_d = ST_RUN;
                    if (dec_req_s) begin
                        // Total rotation over a schedule is 28, so unrotated PC-1 is C16/D16.
                        c_d     = pc1_s[CD_W-1:HALF_W];
                        d_d     = pc1_s[HALF_W-1:0];
                        round_d = 4'(ROUNDS - 1);
                    end else begin
                        c_d     = rot_c_s;
                        d_d     = rot_d_s;
                        round_d = 4'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (subkey_ready) begin
                    if (final_s) begin
                        state_d = ST_DONE;
                    end else begin
                        c_d     = rot_c_s;
                        d_d     = rot_d_s;
                        round_d = dec_q ? round_q - 4'd1 : round_q + 4'd1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and key-half registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= 4'd0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            dec_q   <= dec_d;
        end
    end

    assign subkey       = pc2({c_q, d_q});
    assign subkey_valid = (state_q == ST_RUN);
    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign round_idx    = round_q;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Self-checking bench for des_key_sched_ctrl: table-driven schedules, random keys and
// backpressure against a reference model, mid-schedule reset, and the rotator unit.
module tb_des_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic        subkey_ready = 1'b1;
    logic [63:0] key_in = 64'd0;
    logic        busy, subkey_valid, done;
    logic [47:0] subkey;
    logic [3:0]  round_idx;

    logic [27:0] rot_in = 28'd0;
    logic [1:0]  rot_amt = 2'd1;
    logic        rot_dir = 1'b0;
    logic [27:0] rot_out;

    int checks = 0;
    int failures = 0;

    logic [47:0] model_ks [16];

`ifdef DES_KEY_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] FIPS_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] FIPS_K16 = 48'hCB3D8B0E17F5;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct packed {
        logic [63:0] key;
        logic        dec;
        int          stall_idx;
        int          stall_len;
        int          busy_idx;
        logic        rnd_ready;
        logic        start_at_done;
        logic        has_exp;
        logic [47:0] exp_first;
        logic [47:0] exp_last;
    } vec_t;

    vec_t tbl [6];

    des_key_sched_ctrl #(.ROUNDS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .busy         (busy),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .done         (done)
    );

    des_key_rot u_rot (
        .in_half   (rot_in),
        .amt       (rot_amt),
        .dir_right (rot_dir),
        .out_half  (rot_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s actual=%h expected=%h", tag, name, act, exp);
        end
    endtask

    function automatic logic [27:0] rotl_ref(input logic [27:0] x, input int s);
        longint unsigned v;
        int sm;
        sm = s % 28;
        v  = {36'd0, x};
        if (sm == 0) return x;
        return 28'(((v << sm) | (v >> (28 - sm))) & 64'h0FFF_FFFF);
    endfunction

    // Subkey r = PC2(C0 <<< sum(shift 1..r), D0 <<< same), computed from scratch for each round.
    function automatic void build_model(input logic [63:0] k);
        longint unsigned cd, w, kk;
        logic [27:0] c0, d0, c, d;
        int tot;
        cd = 0;
        for (int i = 0; i < 56; i++) cd = (cd << 1) | ((k >> (64 - PC1_T[i])) & 64'd1);
        c0  = 28'(cd >> 28);
        d0  = 28'(cd);
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += SH_T[r];
            c  = rotl_ref(c0, tot);
            d  = rotl_ref(d0, tot);
            w  = {8'd0, c, d};
            kk = 0;
            for (int j = 0; j < 48; j++) kk = (kk << 1) | ((w >> (56 - PC2_T[j])) & 64'd1);
            model_ks[r] = 48'(kk);
        end
    endfunction

    function automatic vec_t mk(input logic [63:0] key, input logic dec, input int stall_idx,
                                input int stall_len, input int busy_idx, input logic rnd_ready,
                                input logic start_at_done, input logic has_exp,
                                input logic [47:0] exp_first, input logic [47:0] exp_last);
        vec_t v;
        v.key = key; v.dec = dec; v.stall_idx = stall_idx; v.stall_len = stall_len;
        v.busy_idx = busy_idx; v.rnd_ready = rnd_ready; v.start_at_done = start_at_done;
        v.has_exp = has_exp; v.exp_first = exp_first; v.exp_last = exp_last;
        return v;
    endfunction

    task automatic run_sched(input vec_t v, input string tag);
        logic        eff_dec;
        int          n, cyc, idx, stall_cnt;
        bit          pulsed, abort;
        logic [47:0] first_sk, last_sk;
        eff_dec = v.dec & DEC_EN;
        build_model(v.key);
        @(negedge clk);
        key_in = v.key; decrypt = v.dec; start = 1'b1; subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; key_in = ~v.key; decrypt = ~v.dec;
        n = 0; cyc = 0; stall_cnt = 0; pulsed = 1'b0; abort = 1'b0;
        first_sk = '0; last_sk = '0;
        while (n < 16 && cyc < 200 && !abort) begin
            if (!subkey_valid) begin
                chk(tag, "valid", 64'(subkey_valid), 64'd1);
                abort = 1'b1;
            end else begin
                idx = eff_dec ? 15 - n : n;
                chk(tag, "round_idx", 64'(round_idx), 64'(idx));
                chk(tag, "subkey", 64'(subkey), 64'(model_ks[idx]));
                chk(tag, "busy", 64'(busy), 64'd1);
                if (n == 0) first_sk = subkey;
                last_sk = subkey;
                start = 1'b0;
                if (idx == v.busy_idx && !pulsed) begin
                    start   = 1'b1;
                    key_in  = {$urandom, $urandom};
                    decrypt = ~v.dec;
                    pulsed  = 1'b1;
                end
                if (idx == v.stall_idx && stall_cnt < v.stall_len) begin
                    subkey_ready = 1'b0;
                    stall_cnt++;
                end else if (v.rnd_ready && $urandom_range(0, 2) == 0) begin
                    subkey_ready = 1'b0;
                end else begin
                    subkey_ready = 1'b1;
                end
                if (subkey_ready) n++;
                cyc++;
                @(negedge clk);
            end
        end
        start = 1'b0; subkey_ready = 1'b1;
        chk(tag, "handshakes", 64'(n), 64'd16);
        chk(tag, "done_pulse", 64'(done), 64'd1);
        chk(tag, "valid_after", 64'(subkey_valid), 64'd0);
        chk(tag, "busy_after", 64'(busy), 64'd0);
        if (v.has_exp) begin
            chk(tag, "first", 64'(first_sk), 64'(v.exp_first));
            chk(tag, "last", 64'(last_sk), 64'(v.exp_last));
        end
        if (v.start_at_done) begin
            start = 1'b1; key_in = {$urandom, $urandom};
        end
        @(negedge clk);
        start = 1'b0;
        chk(tag, "done_one_cycle", 64'(done), 64'd0);
        chk(tag, "idle_busy", 64'(busy), 64'd0);
        chk(tag, "idle_valid", 64'(subkey_valid), 64'd0);
    endtask

    initial begin
        int cyc;
        logic [47:0] dfirst, dlast;

        rot_in = 28'h8000001; rot_amt = 2'd1; rot_dir = 1'b0; #1;
        chk("rot", "rotl1", 64'(rot_out), 64'h0000003);
        rot_amt = 2'd2; #1;
        chk("rot", "rotl2", 64'(rot_out), 64'h0000006);
        rot_amt = 2'd1; rot_dir = 1'b1; #1;
        chk("rot", "rotr1", 64'(rot_out), 64'hC000000);

        rst_n = 1'b0; #1;
        chk("reset", "busy", 64'(busy), 64'd0);
        chk("reset", "valid", 64'(subkey_valid), 64'd0);
        chk("reset", "done", 64'(done), 64'd0);
        chk("reset", "subkey", 64'(subkey), 64'd0);
        chk("reset", "round_idx", 64'(round_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        dfirst = DEC_EN ? FIPS_K16 : FIPS_K1;
        dlast  = DEC_EN ? FIPS_K1  : FIPS_K16;
        tbl[0] = mk(FIPS_KEY, 1'b0, -1, 0, -1, 1'b0, 1'b0, 1'b1, FIPS_K1, FIPS_K16);
        tbl[1] = mk(FIPS_KEY, 1'b1, -1, 0, -1, 1'b0, 1'b0, 1'b1, dfirst, dlast);
        tbl[2] = mk(FIPS_KEY, 1'b0,  4, 3, -1, 1'b0, 1'b0, 1'b1, FIPS_K1, FIPS_K16);
        tbl[3] = mk(FIPS_KEY, 1'b0, -1, 0,  7, 1'b0, 1'b0, 1'b1, FIPS_K1, FIPS_K16);
        tbl[4] = mk(FIPS_KEY ^ 64'h0101010101010101, 1'b0, -1, 0, -1, 1'b0, 1'b1, 1'b1, FIPS_K1, FIPS_K16);
        tbl[5] = mk(FIPS_KEY, 1'b1,  4, 3,  9, 1'b0, 1'b1, 1'b1, dfirst, dlast);
        for (int i = 0; i < 6; i++) run_sched(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            run_sched(mk({$urandom, $urandom}, 1'($urandom_range(0, 1)), -1, 0, -1, 1'b1, 1'b0,
                         1'b0, 48'd0, 48'd0), $sformatf("rnd%0d", i));
        end

        // Reset while round 10 is being presented.
        build_model(FIPS_KEY);
        @(negedge clk);
        key_in = FIPS_KEY; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (round_idx != 4'd9 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst", "reached_r10", 64'(round_idx), 64'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst", "busy", 64'(busy), 64'd0);
        chk("midrst", "valid", 64'(subkey_valid), 64'd0);
        chk("midrst", "done", 64'(done), 64'd0);
        chk("midrst", "round_idx", 64'(round_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst", "no_done", 64'(done), 64'd0);
            chk("midrst", "idle", 64'(busy), 64'd0);
        end
        run_sched(tbl[0], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
